// File: rtl/cam_pkg.sv
// Shared constants, state encoding and colour helper for camera_frame_writer.
// Ports: none (package).
package cam_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int DECIM_DEF    = 2;
  localparam int ADDR_W_DEF   = 17;

  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

  localparam int RGB444_W = 12;

  typedef enum logic {
    SYNC    = 1'b0,
    CAPTURE = 1'b1
  } state_t;

  // Keep the top four bits of each field, no rounding.
  function automatic logic [RGB444_W-1:0] rgb565_to_444(
    input logic [15:0] pd
  );
    return {pd[R_MSB -: 4], pd[G_MSB -: 4], pd[B_MSB -: 4]};
  endfunction

endpackage

// File: rtl/camera_frame_writer_if.sv
// Pixel-in / BRAM-write bundle for camera_frame_writer.
// master: pixel source + frame-store observer; slave: the writer.
interface camera_frame_writer_if #(
  parameter int ADDR_W = 17
);
  import cam_pkg::*;

  logic                enable;
  logic [15:0]         pixel_data;
  logic                pixel_valid;
  logic                frame_done;
  logic                wr_en;
  logic                wr_buf;
  logic [ADDR_W-1:0]   wr_addr;
  logic [RGB444_W-1:0] wr_data;
  logic                rd_buf;
  logic                frame_ready;
  logic                frame_error;

  modport master (
    output enable, pixel_data, pixel_valid, frame_done,
    input  wr_en, wr_buf, wr_addr, wr_data,
    input  rd_buf, frame_ready, frame_error
  );

  modport slave (
    input  enable, pixel_data, pixel_valid, frame_done,
    output wr_en, wr_buf, wr_addr, wr_data,
    output rd_buf, frame_ready, frame_error
  );

endinterface

// File: rtl/cam_pixel_counter.sv
// x/y position, sticky overflow, keep decision, complete-frame flag.
// Ports: clk_i, rst_n_i, clr_i, cnt_i in; keep_o, complete_o out.
module cam_pixel_counter #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int DECIM    = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic cnt_i,
  output logic keep_o,
  output logic complete_o
);
  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam logic [XW-1:0] XM = XW'(DECIM - 1);
  localparam logic [YW-1:0] YM = YW'(DECIM - 1);

  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic          ovf_q;
  logic          at_end;

  assign at_end = (y_q == YW'(V_ACTIVE));

  // DECIM is a power of two, so masking low bits is mod DECIM.
  assign keep_o = cnt_i && !at_end &&
                  ((x_q & XM) == '0) && ((y_q & YM) == '0);

  assign complete_o = at_end && (x_q == '0) && !ovf_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || clr_i) begin
      x_q   <= '0;
      y_q   <= '0;
      ovf_q <= 1'b0;
    end else if (cnt_i) begin
      if (at_end) begin
        ovf_q <= 1'b1;
      end else if (x_q == XW'(H_ACTIVE - 1)) begin
        x_q <= '0;
        y_q <= y_q + 1'b1;
      end else begin
        x_q <= x_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/camera_frame_writer.sv
// Decimating RGB565->RGB444 writer into a double-buffered frame store.
// Ports: p_clock, reset_n, bus (slave: pixels in, BRAM writes out).
module camera_frame_writer
  import cam_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int DECIM    = DECIM_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic                 p_clock,
  input  logic                 reset_n,
  camera_frame_writer_if.slave bus
);
  state_t              state_q;
  logic                wr_buf_q;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic [RGB444_W-1:0] wr_data_q;
  logic                ready_q;
  logic                error_q;
  logic                fd;
  logic                pix_go;
  logic                keep;
  logic                complete;

  assign fd = bus.frame_done;

  // frame_done wins over a coincident pixel.
  assign pix_go = (state_q == CAPTURE) && bus.pixel_valid && !fd;

  cam_pixel_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .DECIM    (DECIM)
  ) u_cnt (
    .clk_i      (p_clock),
    .rst_n_i    (reset_n),
    .clr_i      (fd),
    .cnt_i      (pix_go),
    .keep_o     (keep),
    .complete_o (complete)
  );

  always_ff @(posedge p_clock) begin
    if (!reset_n) begin
      state_q   <= SYNC;
      wr_buf_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      cnt_q     <= '0;
      wr_data_q <= '0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      if (keep) begin
        wr_en_q   <= 1'b1;
        wr_addr_q <= cnt_q;
        wr_data_q <= rgb565_to_444(bus.pixel_data);
        cnt_q     <= cnt_q + 1'b1;
      end
      unique case (state_q)
        SYNC: begin
          if (fd && bus.enable) begin
            state_q <= CAPTURE;
            cnt_q   <= '0;
          end
        end
        CAPTURE: begin
          if (fd) begin
            cnt_q   <= '0;
            state_q <= bus.enable ? CAPTURE : SYNC;
            // A write issued this cycle still carries the old buffer.
            if (complete) begin
              wr_buf_q <= ~wr_buf_q;
              ready_q  <= 1'b1;
            end else begin
              error_q  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.wr_en       = wr_en_q;
  assign bus.wr_buf      = wr_buf_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.rd_buf      = ~wr_buf_q;
  assign bus.frame_ready = ready_q;
  assign bus.frame_error = error_q;

endmodule

// File: tb/tb_camera_frame_writer.sv
// Scoreboard bench for camera_frame_writer at 8x4, DECIM=2.
// Ports: none.
module tb_camera_frame_writer;
  import cam_pkg::*;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int D  = 2;
  localparam int AW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  camera_frame_writer_if #(.ADDR_W(AW)) bus();

  camera_frame_writer #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .DECIM    (D),
    .ADDR_W   (AW)
  ) dut (
    .p_clock (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    int          cyc;
    logic [31:0] val;
  } exp_t;

  exp_t wq[$];
  exp_t eq[$];

  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc_n  = 0;
  int   n_wr   = 0;
  logic mon_on = 1'b0;

  int   m_st, mx, my, movf, mcnt;
  logic mbuf;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    exp_t e;
    if (mon_on) begin
      chk("rd_buf_inv", {31'b0, bus.rd_buf ^ bus.wr_buf}, 32'd1);
      if (bus.wr_en) begin
        n_wr++;
        if (wq.size() == 0) chk("unexp_write", 32'd1, 32'd0);
        else begin
          e = wq.pop_front();
          chk("wr_cycle", cyc_n, e.cyc);
          chk("wr_word", {15'b0, bus.wr_buf, bus.wr_addr, bus.wr_data},
              e.val);
        end
      end
      if (bus.frame_ready || bus.frame_error) begin
        if (eq.size() == 0) chk("unexp_event", 32'd1, 32'd0);
        else begin
          e = eq.pop_front();
          chk("ev_cycle", cyc_n, e.cyc);
          chk("ev_kind", {30'b0, bus.frame_error, bus.frame_ready}, e.val);
        end
      end
    end
  end

  function automatic logic [11:0] conv(input logic [15:0] p);
    return {p[15:12], p[10:7], p[4:1]};
  endfunction

  task automatic mclear();
    mx = 0; my = 0; movf = 0; mcnt = 0;
  endtask

  task automatic model(input logic en, input logic pv, input logic fd,
                       input logic [15:0] pd, input logic rn);
    exp_t e;
    bit   ok;
    e.cyc = cyc_n + 1;
    if (!rn) begin
      m_st = 0; mbuf = 1'b0; mclear();
    end else if (m_st == 0) begin
      if (fd && en) begin m_st = 1; mclear(); end
    end else if (fd) begin
      ok = (my == V) && (mx == 0) && (movf == 0);
      e.val = ok ? 32'd1 : 32'd2;
      eq.push_back(e);
      if (ok) mbuf = ~mbuf;
      mclear();
      m_st = en ? 1 : 0;
    end else if (pv) begin
      if (my == V) movf = 1;
      else begin
        if (mx % D == 0 && my % D == 0) begin
          e.val = {15'b0, mbuf, 4'(mcnt), conv(pd)};
          wq.push_back(e);
          mcnt++;
        end
        mx++;
        if (mx == H) begin mx = 0; my++; end
      end
    end
  endtask

  task automatic step(input logic en, input logic pv, input logic fd,
                      input logic [15:0] pd, input logic rn);
    bus.enable      = en;
    bus.pixel_valid = pv;
    bus.frame_done  = fd;
    bus.pixel_data  = pd;
    rst_n           = rn;
    model(en, pv, fd, pd, rn);
    @(posedge clk);
    #1;
  endtask

  task automatic pixels(input int n, input bit fixed,
                        input logic [15:0] d, input logic en);
    logic [15:0] p;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) step(en, 1'b0, 1'b0, 16'h0, 1'b1);
      p = fixed ? d : 16'($urandom);
      step(en, 1'b1, 1'b0, p, 1'b1);
    end
  endtask

  task automatic fdone(input logic en);
    step(en, 1'b0, 1'b1, 16'h0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
  endtask

  task automatic check_reset(input string t);
    chk({t, "_wr_en"},   {31'b0, bus.wr_en},       32'd0);
    chk({t, "_wr_addr"}, {28'b0, bus.wr_addr},     32'd0);
    chk({t, "_wr_data"}, {20'b0, bus.wr_data},     32'd0);
    chk({t, "_wr_buf"},  {31'b0, bus.wr_buf},      32'd0);
    chk({t, "_rd_buf"},  {31'b0, bus.rd_buf},      32'd1);
    chk({t, "_ready"},   {31'b0, bus.frame_ready}, 32'd0);
    chk({t, "_error"},   {31'b0, bus.frame_error}, 32'd0);
  endtask

  int w0;

  initial begin
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    mon_on = 1'b1;
    step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    check_reset("rst");

    // Pixels before the first frame_done are ignored.
    w0 = n_wr;
    pixels(6, 1'b0, 16'h0, 1'b1);
    idle(2);
    chk("sync_no_write", n_wr - w0, 32'd0);
    fdone(1'b1);

    // Complete frame of magenta.
    w0 = n_wr;
    pixels(32, 1'b1, 16'hF81F, 1'b1);
    fdone(1'b1);
    idle(2);
    chk("t1_writes", n_wr - w0, 32'd8);
    chk("t1_wr_buf", {31'b0, bus.wr_buf}, 32'd1);
    chk("t1_rd_buf", {31'b0, bus.rd_buf}, 32'd0);

    // Short frame.
    pixels(31, 1'b0, 16'h0, 1'b1);
    fdone(1'b1);
    idle(2);
    chk("t2_wr_buf", {31'b0, bus.wr_buf}, 32'd1);

    // Full frame after the short one restarts at address 0.
    pixels(32, 1'b0, 16'h0, 1'b1);
    fdone(1'b1);
    idle(2);
    chk("t2b_wr_buf", {31'b0, bus.wr_buf}, 32'd0);

    // Long frame.
    w0 = n_wr;
    pixels(33, 1'b0, 16'h0, 1'b1);
    fdone(1'b1);
    idle(2);
    chk("t3_writes", n_wr - w0, 32'd8);
    chk("t3_wr_buf", {31'b0, bus.wr_buf}, 32'd0);

    // Pixel coincident with frame_done is dropped.
    w0 = n_wr;
    pixels(32, 1'b0, 16'h0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b1);
    idle(2);
    chk("t5_writes", n_wr - w0, 32'd8);
    chk("t5_wr_buf", {31'b0, bus.wr_buf}, 32'd1);

    // enable low at frame_done drops back to SYNC.
    pixels(32, 1'b0, 16'h0, 1'b1);
    fdone(1'b0);
    idle(2);
    w0 = n_wr;
    pixels(8, 1'b0, 16'h0, 1'b1);
    idle(2);
    chk("t6_sync_writes", n_wr - w0, 32'd0);
    fdone(1'b1);

    // Reset mid-frame.
    pixels(10, 1'b0, 16'h0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 16'h1234, 1'b0);
    check_reset("midrst");
    idle(3);

    chk("wq_empty", wq.size(), 32'd0);
    chk("eq_empty", eq.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
